// File: rtl/saida_display_if.sv
// Bus between the output register and the 3-digit display driver:
// load strobe and value in, segment/anode drive and status out.
interface saida_display_if;
  logic [7:0] dado;
  logic       carregar;
  logic [6:0] seg;
  logic [2:0] an;
  logic       ocupado;
  logic       pronto;

  modport master (
    output dado, carregar,
    input  seg, an, ocupado, pronto
  );

  modport slave (
    input  dado, carregar,
    output seg, an, ocupado, pronto
  );
endinterface

// File: rtl/saida_display.sv
// 8-bit binary to 3-digit multiplexed 7-segment driver with sequential double-dabble.
// Optional leading-zero blanking is enabled by defining SAIDA_DISPLAY_ZERO_BLANK_EN.
module saida_display #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic             CLK,
  input  logic             CLR,
  saida_display_if.slave   bus
);

  typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  shift_cnt_reg;
  logic [7:0]  bin_reg;
  logic [11:0] bcd_reg;
  logic [11:0] bcd_adj;
  logic [7:0]  pend_reg;
  logic        pend_valid_reg;
  logic [11:0] shown_reg;
  logic        pronto_reg;
  logic [15:0] ref_cnt_reg;
  logic [1:0]  sel_reg;

  logic        start_en;
  logic [7:0]  start_val;
  logic        shift_en;
  logic        commit_en;
  logic        pend_load;
  logic        pend_clear;
  logic        ocupado_int;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (CLR) state_reg <= OCIOSO;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO:  if (bus.carregar) state_next = DESLOCA;
      DESLOCA: if (shift_cnt_reg == 3'd7) state_next = FIM;
      FIM:     state_next = (pend_valid_reg || bus.carregar) ? DESLOCA : OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A load arriving on the commit cycle with nothing pending starts directly,
  // otherwise it lands in the pending register so nothing is dropped.
  always_comb begin
    ocupado_int = 1'b0;
    start_en    = 1'b0;
    start_val   = bus.dado;
    shift_en    = 1'b0;
    commit_en   = 1'b0;
    pend_load   = 1'b0;
    pend_clear  = 1'b0;
    case (state_reg)
      OCIOSO: begin
        start_en = bus.carregar;
      end
      DESLOCA: begin
        ocupado_int = 1'b1;
        shift_en    = 1'b1;
        pend_load   = bus.carregar;
      end
      FIM: begin
        ocupado_int = 1'b1;
        commit_en   = 1'b1;
        start_en    = pend_valid_reg || bus.carregar;
        if (pend_valid_reg) begin
          start_val  = pend_reg;
          pend_load  = bus.carregar;
          pend_clear = !bus.carregar;
        end
      end
      default: ;
    endcase
  end

  // ---------------- double-dabble datapath ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (CLR) begin
      shift_cnt_reg <= 3'd0;
      bin_reg       <= 8'd0;
      bcd_reg       <= 12'd0;
    end else if (start_en) begin
      shift_cnt_reg <= 3'd0;
      bin_reg       <= start_val;
      bcd_reg       <= 12'd0;
    end else if (shift_en) begin
      shift_cnt_reg       <= shift_cnt_reg + 3'd1;
      {bcd_reg, bin_reg}  <= {bcd_adj, bin_reg} << 1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      pend_reg       <= 8'd0;
      pend_valid_reg <= 1'b0;
    end else if (pend_load) begin
      pend_reg       <= bus.dado;
      pend_valid_reg <= 1'b1;
    end else if (pend_clear) begin
      pend_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      shown_reg  <= 12'd0;
      pronto_reg <= 1'b0;
    end else begin
      pronto_reg <= commit_en;
      if (commit_en) shown_reg <= bcd_reg;
    end
  end

  // ---------------- digit scan ----------------
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ref_cnt_reg <= 16'd0;
      sel_reg     <= 2'd0;
    end else if (ref_cnt_reg == 16'(REFRESH_DIV - 1)) begin
      ref_cnt_reg <= 16'd0;
      sel_reg     <= (sel_reg == 2'd2) ? 2'd0 : sel_reg + 2'd1;
    end else begin
      ref_cnt_reg <= ref_cnt_reg + 16'd1;
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_an
      assign bus.an[gi] = (sel_reg != 2'(gi));
    end
  endgenerate

  logic [2:0] blank;
`ifdef SAIDA_DISPLAY_ZERO_BLANK_EN
  assign blank[2] = (shown_reg[11:8] == 4'd0);
  assign blank[1] = (shown_reg[11:8] == 4'd0) && (shown_reg[7:4] == 4'd0);
  assign blank[0] = 1'b0;
`else
  assign blank = 3'b000;
`endif

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  logic [3:0] cur_digit;
  logic       cur_blank;
  always_comb begin
    cur_digit = shown_reg[3:0];
    cur_blank = blank[0];
    case (sel_reg)
      2'd1: begin
        cur_digit = shown_reg[7:4];
        cur_blank = blank[1];
      end
      2'd2: begin
        cur_digit = shown_reg[11:8];
        cur_blank = blank[2];
      end
      default: ;
    endcase
  end

  assign bus.seg     = cur_blank ? 7'b1111111 : seg_enc(cur_digit);
  assign bus.ocupado = ocupado_int;
  assign bus.pronto  = pronto_reg;

endmodule

// File: tb/tb_saida_display.sv
// Directed bench for saida_display: vector table of conversions plus
// hand-written pending, commit-cycle load, abort and scan sequences.
module tb_saida_display;

  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  saida_display_if bus ();

  saida_display #(.REFRESH_DIV(4)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] dado;
    int         h;
    int         t;
    int         u;
  } vec_t;

  vec_t vecs [10];
  int total = 0;
  int bad   = 0;
  int exp_h = 0, exp_t = 0, exp_u = 0;
  logic [2:0] an_pats [3];

  function automatic logic [6:0] enc(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg_for(input logic [2:0] a);
    logic bh, bt;
    bh = 1'b0;
    bt = 1'b0;
`ifdef SAIDA_DISPLAY_ZERO_BLANK_EN
    bh = (exp_h == 0);
    bt = (exp_h == 0) && (exp_t == 0);
`endif
    case (a)
      3'b110:  return enc(exp_u);
      3'b101:  return bt ? 7'b1111111 : enc(exp_t);
      3'b011:  return bh ? 7'b1111111 : enc(exp_h);
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_disp(input string name);
    check({name, "_an"}, 32'(bus.an == 3'b110 || bus.an == 3'b101 || bus.an == 3'b011), 32'd1);
    check({name, "_seg"}, 32'(bus.seg), 32'(exp_seg_for(bus.an)));
  endtask

  task automatic scan_all(input string name);
    repeat (12) begin
      tick();
      check_disp(name);
    end
  endtask

  initial begin
    vecs[0] = '{8'd0,   0, 0, 0};
    vecs[1] = '{8'd7,   0, 0, 7};
    vecs[2] = '{8'd9,   0, 0, 9};
    vecs[3] = '{8'd10,  0, 1, 0};
    vecs[4] = '{8'd42,  0, 4, 2};
    vecs[5] = '{8'd99,  0, 9, 9};
    vecs[6] = '{8'd100, 1, 0, 0};
    vecs[7] = '{8'd128, 1, 2, 8};
    vecs[8] = '{8'd200, 2, 0, 0};
    vecs[9] = '{8'd255, 2, 5, 5};
    an_pats[0] = 3'b110;
    an_pats[1] = 3'b101;
    an_pats[2] = 3'b011;

    CLR = 1'b1;
    bus.carregar = 1'b0;
    bus.dado = 8'd0;
    repeat (3) tick();
    check("rst_ocupado", 32'(bus.ocupado), 32'd0);
    check("rst_pronto",  32'(bus.pronto),  32'd0);
    check("rst_an",      32'(bus.an),      32'(3'b110));
    check("rst_seg",     32'(bus.seg),     32'(7'b1000000));
    CLR = 1'b0;

    // table of single conversions: latency, busy flag, held/new display
    for (int i = 0; i < 10; i++) begin
      int lat;
      bus.dado = vecs[i].dado;
      bus.carregar = 1'b1;
      tick();
      bus.carregar = 1'b0;
      check("vec_ocupado_start", 32'(bus.ocupado), 32'd1);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (bus.pronto) begin
          lat = k;
          break;
        end
        check_disp("vec_hold");
      end
      check("vec_latency", 32'(lat), 32'd9);
      check("vec_ocupado_done", 32'(bus.ocupado), 32'd0);
      exp_h = vecs[i].h;
      exp_t = vecs[i].t;
      exp_u = vecs[i].u;
      check_disp("vec_commit");
      tick();
      check("vec_pronto_pulse", 32'(bus.pronto), 32'd0);
      scan_all("vec_digits");
    end

    // 100 at t, 42 at t+3, 99 at t+5: 42 overwritten, 99 follows 9 cycles later
    bus.dado = 8'd100; bus.carregar = 1'b1;
    tick();
    bus.carregar = 1'b0;
    tick(); tick();
    bus.dado = 8'd42; bus.carregar = 1'b1;
    tick();
    bus.carregar = 1'b0;
    tick();
    bus.dado = 8'd99; bus.carregar = 1'b1;
    tick();
    bus.carregar = 1'b0;
    repeat (3) begin
      tick();
      check("pend_pronto_early", 32'(bus.pronto), 32'd0);
      check_disp("pend_hold255");
    end
    tick();
    check("pend_pronto1", 32'(bus.pronto), 32'd1);
    check("pend_ocupado", 32'(bus.ocupado), 32'd1);
    exp_h = 1; exp_t = 0; exp_u = 0;
    check_disp("pend_show100");
    repeat (8) begin
      tick();
      check("pend_pronto_gap", 32'(bus.pronto), 32'd0);
      check_disp("pend_hold100");
    end
    tick();
    check("pend_pronto2", 32'(bus.pronto), 32'd1);
    exp_h = 0; exp_t = 9; exp_u = 9;
    scan_all("pend_show099");

    // load arriving on the commit cycle must not be lost
    bus.dado = 8'd33; bus.carregar = 1'b1;
    tick();
    bus.carregar = 1'b0;
    repeat (8) tick();
    bus.dado = 8'd150; bus.carregar = 1'b1;
    tick();
    bus.carregar = 1'b0;
    check("fimld_pronto1", 32'(bus.pronto), 32'd1);
    check("fimld_ocupado", 32'(bus.ocupado), 32'd1);
    exp_h = 0; exp_t = 3; exp_u = 3;
    check_disp("fimld_show033");
    repeat (8) begin
      tick();
      check("fimld_pronto_gap", 32'(bus.pronto), 32'd0);
      check_disp("fimld_hold033");
    end
    tick();
    check("fimld_pronto2", 32'(bus.pronto), 32'd1);
    exp_h = 1; exp_t = 5; exp_u = 0;
    scan_all("fimld_show150");

    // reset mid-conversion aborts, ignores the simultaneous load, restarts scan
    bus.dado = 8'd200; bus.carregar = 1'b1;
    tick();
    bus.carregar = 1'b0;
    repeat (3) tick();
    CLR = 1'b1;
    bus.dado = 8'd55; bus.carregar = 1'b1;
    tick();
    CLR = 1'b0;
    bus.carregar = 1'b0;
    check("abort_ocupado", 32'(bus.ocupado), 32'd0);
    check("abort_pronto",  32'(bus.pronto),  32'd0);
    check("abort_an",      32'(bus.an),      32'(3'b110));
    check("abort_seg",     32'(bus.seg),     32'(7'b1000000));
    exp_h = 0; exp_t = 0; exp_u = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      check("scan_an", 32'(bus.an), 32'(an_pats[(k / 4) % 3]));
      check("abort_no_pronto", 32'(bus.pronto), 32'd0);
      check("abort_idle", 32'(bus.ocupado), 32'd0);
      check_disp("abort_show000");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
